// File: rtl/shift_sequencer.sv
// Bit-serial shift controller: performs a 0..WIDTH-1 position shift one bit per clock.
// Optional rotate mode is compiled in when SHIFT_ROTATE_EN is defined.
module shift_sequencer #(
   parameter int WIDTH = 32,
   parameter int AMT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_data,
   input  logic [AMT_W-1:0] req_amount,
   input  logic             req_dir,
   input  logic             req_rot,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_data,
   output logic             resp_carry,
   output logic             busy
);

   // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
   // Producers hold their payload stable while valid is high and ready is low.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic               carry_q, carry_d;
   logic [AMT_W-1:0]   cnt_q, cnt_d;
   logic               dir_q, dir_d;
   logic               fill_bit;

`ifdef SHIFT_ROTATE_EN
   logic               rot_q, rot_d;

   always_comb begin
      fill_bit = rot_q & (dir_q ? data_q[0] : data_q[WIDTH-1]);
   end
`else
   logic               unused_rot;

   assign unused_rot = req_rot;

   always_comb begin
      fill_bit = 1'b0;
   end
`endif

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
`ifdef SHIFT_ROTATE_EN
      rot_d   = rot_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               data_d  = req_data;
               cnt_d   = req_amount;
               dir_d   = req_dir;
               carry_d = 1'b0;
`ifdef SHIFT_ROTATE_EN
               rot_d   = req_rot;
`endif
               state_d = (req_amount == '0) ? ST_DONE : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (dir_q) begin
               carry_d = data_q[0];
               data_d  = {fill_bit, data_q[WIDTH-1:1]};
            end else begin
               carry_d = data_q[WIDTH-1];
               data_d  = {data_q[WIDTH-2:0], fill_bit};
            end
            cnt_d = cnt_q - AMT_W'(1);
            if (cnt_q == AMT_W'(1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            // Result registers are untouched here, so the response stays frozen under backpressure.
            if (resp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
`ifdef SHIFT_ROTATE_EN
         rot_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
`ifdef SHIFT_ROTATE_EN
         rot_q   <= rot_d;
`endif
      end
   end

   assign req_ready  = (state_q == ST_IDLE);
   assign resp_valid = (state_q == ST_DONE);
   assign busy       = (state_q != ST_IDLE);
   assign resp_data  = data_q;
   assign resp_carry = carry_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: driver pushes expected results, a negedge monitor
// checks latency, payload stability under backpressure and the response values.
module tb_shift_sequencer;

   localparam int WIDTH = 32;
   localparam int AMT_W = 5;

   logic             clk;
   logic             rst_n;
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] req_data;
   logic [AMT_W-1:0] req_amount;
   logic             req_dir;
   logic             req_rot;
   logic             resp_valid;
   logic             resp_ready;
   logic [WIDTH-1:0] resp_data;
   logic             resp_carry;
   logic             busy;

   shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_data   (req_data),
      .req_amount (req_amount),
      .req_dir    (req_dir),
      .req_rot    (req_rot),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_carry (resp_carry),
      .busy       (busy)
   );

   // clock / cycle counter
   int cyc = 0;
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   logic [WIDTH-1:0] exp_data_q[$];
   logic             exp_carry_q[$];
   int               exp_rise_q[$];

   task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Drive one request and return the counter value of the cycle right after the accept edge.
   task automatic accept_req(input logic [WIDTH-1:0] d, input logic [AMT_W-1:0] amt,
                             input logic dir, input logic rot, output int acc);
      int guard;
      @(negedge clk);
      req_valid  = 1'b1;
      req_data   = d;
      req_amount = amt;
      req_dir    = dir;
      req_rot    = rot;
      guard = 0;
      while (!req_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) begin
         n_checks++;
         n_errors++;
         $display("FAIL accept_timeout: req_ready stuck low");
      end
      @(posedge clk);
      #1;
      acc = cyc;
      req_valid  = 1'b0;
      // Scramble inputs while busy; the DUT must ignore them.
      req_data   = ~d;
      req_amount = ~amt;
      req_dir    = ~dir;
      req_rot    = ~rot;
   endtask

   task automatic send(input logic [WIDTH-1:0] d, input logic [AMT_W-1:0] amt,
                       input logic dir, input logic rot,
                       input logic [WIDTH-1:0] e_data, input logic e_carry);
      int acc;
      accept_req(d, amt, dir, rot, acc);
      exp_data_q.push_back(e_data);
      exp_carry_q.push_back(e_carry);
      exp_rise_q.push_back(acc + int'(amt));
   endtask

   task automatic wait_drained();
      int guard;
      guard = 0;
      while ((exp_data_q.size() != 0 || !req_ready) && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 300) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain_timeout: %0d responses outstanding", exp_data_q.size());
      end
   endtask

   // monitor / scoreboard
   logic prev_valid = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_valid <= 1'b0;
      end else begin
         if (resp_valid) begin
            if (exp_data_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_resp: resp_valid with empty scoreboard, data 0x%08h", resp_data);
            end else begin
               if (!prev_valid) chk("resp_latency", WIDTH'(cyc), WIDTH'(exp_rise_q[0]));
               chk("resp_data", resp_data, exp_data_q[0]);
               chk("resp_carry", WIDTH'(resp_carry), WIDTH'(exp_carry_q[0]));
               chk("req_ready_in_done", WIDTH'(req_ready), 0);
               chk("busy_in_done", WIDTH'(busy), 1);
               if (resp_ready) begin
                  void'(exp_data_q.pop_front());
                  void'(exp_carry_q.pop_front());
                  void'(exp_rise_q.pop_front());
               end
            end
         end
         prev_valid <= resp_valid && !resp_ready;
      end
   end

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, WIDTH'(req_ready), 1);
      chk({tag, "_resp_valid"}, WIDTH'(resp_valid), 0);
      chk({tag, "_resp_data"}, resp_data, 0);
      chk({tag, "_resp_carry"}, WIDTH'(resp_carry), 0);
      chk({tag, "_busy"}, WIDTH'(busy), 0);
   endtask

   logic [WIDTH-1:0] rot_exp;
   int acc;

   initial begin
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_data   = '0;
      req_amount = '0;
      req_dir    = 1'b0;
      req_rot    = 1'b0;
      resp_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset_outputs("por");
      rst_n = 1'b1;

      // Reset mid-SHIFT: accept, then pull rst_n low during cycle 3.
      accept_req(32'h8000_0001, 5'd7, 1'b0, 1'b0, acc);
      @(negedge clk);
      chk("mid_shift_busy", WIDTH'(busy), 1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("abort");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("after_release_req_ready", WIDTH'(req_ready), 1);

      // Directed vectors with hand-computed results.
      send(32'h8000_0001, 5'd1, 1'b0, 1'b0, 32'h0000_0002, 1'b1);
      wait_drained();
      send(32'h0000_00F0, 5'd5, 1'b1, 1'b0, 32'h0000_0007, 1'b1);
      wait_drained();
      send(32'hDEAD_BEEF, 5'd0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);
      wait_drained();
      send(32'h1234_5678, 5'd4, 1'b0, 1'b0, 32'h2345_6780, 1'b1);
      wait_drained();
      send(32'h0000_00A5, 5'd3, 1'b1, 1'b0, 32'h0000_0014, 1'b1);
      wait_drained();
      send(32'h8000_0000, 5'd31, 1'b1, 1'b0, 32'h0000_0001, 1'b0);
      wait_drained();

`ifdef SHIFT_ROTATE_EN
      rot_exp = 32'h1800_0000;
`else
      rot_exp = 32'h0800_0000;
`endif
      send(32'h8000_0001, 5'd4, 1'b1, 1'b1, rot_exp, 1'b0);
      wait_drained();

      // Backpressure: hold resp_ready low for 10 cycles once the result is up.
      @(negedge clk);
      resp_ready = 1'b0;
      send(32'h0000_0001, 5'd31, 1'b0, 1'b0, 32'h8000_0000, 1'b0);
      begin
         int guard;
         guard = 0;
         while (!resp_valid && guard < 100) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 100) begin
            n_checks++;
            n_errors++;
            $display("FAIL bp_timeout: resp_valid never rose");
         end
      end
      repeat (10) @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_req_ready_after", WIDTH'(req_ready), 1);
      chk("bp_resp_valid_after", WIDTH'(resp_valid), 0);
      wait_drained();

      chk("scoreboard_empty", WIDTH'(exp_data_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
      $fatal(1, "timeout");
   end

endmodule
